// File: rtl/vga_scan_gen.sv
// Raster-scan timing generator: pixel-enable divider, x/y scan counters, syncs and strobes.
// Define VGA_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module vga_scan_gen #(
    parameter int unsigned H_DISPLAY   = 640,
    parameter int unsigned H_FRONT     = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BACK      = 48,
    parameter int unsigned V_DISPLAY   = 480,
    parameter int unsigned V_FRONT     = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BACK      = 33,
    parameter int unsigned CLK_DIV     = 4,
    parameter bit          SYNC_ACTIVE = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       p_tick,
    output logic       line_start,
    output logic       frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    if (H_TOTAL > 1024 || H_TOTAL < 1) begin : g_bad_h_total
        $error("vga_scan_gen: H_TOTAL must be 1..1024");
    end
    if (V_TOTAL > 1024 || V_TOTAL < 1) begin : g_bad_v_total
        $error("vga_scan_gen: V_TOTAL must be 1..1024");
    end
    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_clk_div
        $error("vga_scan_gen: CLK_DIV must be 1..16");
    end

    localparam logic [9:0]  H_MAX    = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_MAX    = 10'(V_TOTAL - 1);
    localparam logic [3:0]  DIV_MAX  = 4'(CLK_DIV - 1);
    localparam logic [10:0] H_VIS    = 11'(H_DISPLAY);
    localparam logic [10:0] V_VIS    = 11'(V_DISPLAY);
    localparam logic [10:0] HS_FIRST = 11'(H_DISPLAY + H_FRONT);
    localparam logic [10:0] HS_LIMIT = 11'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_FIRST = 11'(V_DISPLAY + V_FRONT);
    localparam logic [10:0] VS_LIMIT = 11'(V_DISPLAY + V_FRONT + V_SYNC);

    logic [3:0] r_div;
    logic       r_p_tick;
    logic [9:0] r_x;
    logic [9:0] r_y;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_video_on;
    logic       r_line_start;
    logic       r_frame_start;

    logic [9:0] w_x_nxt;
    logic [9:0] w_y_nxt;
    logic       w_line_wrap;
    logic       w_frame_wrap;
    logic       w_hs_act;
    logic       w_vs_act;
    logic       w_video;

    assign w_line_wrap  = r_p_tick && (r_x == H_MAX);
    assign w_frame_wrap = w_line_wrap && (r_y == V_MAX);

    always_comb begin
        w_x_nxt = r_x;
        w_y_nxt = r_y;
        if (r_p_tick) begin
            if (r_x == H_MAX) begin
                w_x_nxt = '0;
                w_y_nxt = (r_y == V_MAX) ? '0 : r_y + 10'd1;
            end else begin
                w_x_nxt = r_x + 10'd1;
            end
        end
    end

    // Decode from next-state counters so registered syncs line up with registered x/y.
    always_comb begin
        w_hs_act = ({1'b0, w_x_nxt} >= HS_FIRST) && ({1'b0, w_x_nxt} < HS_LIMIT);
        w_vs_act = ({1'b0, w_y_nxt} >= VS_FIRST) && ({1'b0, w_y_nxt} < VS_LIMIT);
        w_video  = ({1'b0, w_x_nxt} < H_VIS) && ({1'b0, w_y_nxt} < V_VIS);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div         <= '0;
            r_p_tick      <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_hsync       <= ~SYNC_ACTIVE;
            r_vsync       <= ~SYNC_ACTIVE;
            r_video_on    <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_div         <= (r_div == DIV_MAX) ? '0 : r_div + 4'd1;
            r_p_tick      <= (r_div == DIV_MAX);
            r_x           <= w_x_nxt;
            r_y           <= w_y_nxt;
            r_hsync       <= w_hs_act ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            r_vsync       <= w_vs_act ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            r_video_on    <= w_video;
            r_line_start  <= w_line_wrap;
            r_frame_start <= w_frame_wrap;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
        end else if (w_frame_wrap) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

    assign x           = r_x;
    assign y           = r_y;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign video_on    = r_video_on;
    assign p_tick      = r_p_tick;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_scan_gen.sv
// Testbench for vga_scan_gen: three instances (default, CLK_DIV=1/active-high sync, small raster)
// checked every cycle against a closed-form model of elapsed clocks since reset release.
module tb_vga_scan_gen;

    typedef struct packed {
        int hd; int hf; int hs; int hb;
        int vd; int vf; int vs; int vb;
        int cd; bit sa;
    } cfg_t;

    localparam cfg_t C_DEF   = '{640, 16, 96, 48, 480, 10, 2, 33, 4, 1'b0};
    localparam cfg_t C_FAST  = '{640, 16, 96, 48, 480, 10, 2, 33, 1, 1'b1};
    localparam cfg_t C_SMALL = '{20, 4, 6, 5, 12, 2, 2, 3, 3, 1'b0};
    localparam int SMALL_FRAME_CLKS = 35 * 19 * 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_def = 1'b0, rst_fast = 1'b0, rst_small = 1'b0;
    int   n_def = 0, n_fast = 0, n_small = 0;
    int   checks = 0, errors = 0;

    logic [9:0] d_x, d_y, f_x, f_y, s_x, s_y;
    logic d_hs, d_vs, d_von, d_pt, d_ls, d_fs;
    logic f_hs, f_vs, f_von, f_pt, f_ls, f_fs;
    logic s_hs, s_vs, s_von, s_pt, s_ls, s_fs;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] d_fc, f_fc, s_fc;
`endif

    // Clocks elapsed since the last edge that sampled reset low.
    always @(posedge clk) begin
        n_def   <= rst_def   ? n_def + 1   : 0;
        n_fast  <= rst_fast  ? n_fast + 1  : 0;
        n_small <= rst_small ? n_small + 1 : 0;
    end

    vga_scan_gen u_def (
        .clk(clk), .rst_n(rst_def), .x(d_x), .y(d_y), .hsync(d_hs), .vsync(d_vs),
        .video_on(d_von), .p_tick(d_pt), .line_start(d_ls), .frame_start(d_fs)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(d_fc)
`endif
    );

    vga_scan_gen #(.CLK_DIV(1), .SYNC_ACTIVE(1'b1)) u_fast (
        .clk(clk), .rst_n(rst_fast), .x(f_x), .y(f_y), .hsync(f_hs), .vsync(f_vs),
        .video_on(f_von), .p_tick(f_pt), .line_start(f_ls), .frame_start(f_fs)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(f_fc)
`endif
    );

    vga_scan_gen #(
        .H_DISPLAY(20), .H_FRONT(4), .H_SYNC(6), .H_BACK(5),
        .V_DISPLAY(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
        .CLK_DIV(3), .SYNC_ACTIVE(1'b0)
    ) u_small (
        .clk(clk), .rst_n(rst_small), .x(s_x), .y(s_y), .hsync(s_hs), .vsync(s_vs),
        .video_on(s_von), .p_tick(s_pt), .line_start(s_ls), .frame_start(s_fs)
`ifdef VGA_FRAME_CNT_EN
        , .frame_cnt(s_fc)
`endif
    );

    // Expected {x, y, hsync, vsync, video_on, p_tick, line_start, frame_start} after n clocks.
    function automatic logic [25:0] model(input cfg_t c, input int n);
        int pix, xx, yy, ht, vt;
        bit step, hs, vs, von, pt, ls, fs;
        if (n == 0) return {10'd0, 10'd0, !c.sa, !c.sa, 4'b0000};
        ht   = c.hd + c.hf + c.hs + c.hb;
        vt   = c.vd + c.vf + c.vs + c.vb;
        pix  = (n - 1) / c.cd;
        xx   = pix % ht;
        yy   = (pix / ht) % vt;
        step = (n > 1) && (((n - 1) % c.cd) == 0);
        hs   = (xx >= c.hd + c.hf && xx < c.hd + c.hf + c.hs) ? c.sa : !c.sa;
        vs   = (yy >= c.vd + c.vf && yy < c.vd + c.vf + c.vs) ? c.sa : !c.sa;
        von  = (xx < c.hd) && (yy < c.vd);
        pt   = (n % c.cd) == 0;
        ls   = step && (xx == 0);
        fs   = step && (xx == 0) && (yy == 0);
        return {10'(xx), 10'(yy), hs, vs, von, pt, ls, fs};
    endfunction

    function automatic int model_frames(input cfg_t c, input int n);
        if (n == 0) return 0;
        return ((n - 1) / c.cd) / ((c.hd + c.hf + c.hs + c.hb) * (c.vd + c.vf + c.vs + c.vb));
    endfunction

    task automatic test_reset();
        logic [25:0] got, exp;
        repeat (3) @(negedge clk);
        got = {d_x, d_y, d_hs, d_vs, d_von, d_pt, d_ls, d_fs};
        exp = model(C_DEF, n_def);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_def got=%h required=%h", got, exp);
        end
        got = {f_x, f_y, f_hs, f_vs, f_von, f_pt, f_ls, f_fs};
        exp = model(C_FAST, n_fast);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_fast got=%h required=%h", got, exp);
        end
    endtask

    task automatic test_scan_lines();
        logic [25:0] got, exp;
        int ls_def = 0, cycles;
        cycles = 3300 + int'($urandom_range(0, 200));
        rst_def  = 1'b1;
        rst_fast = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            got = {d_x, d_y, d_hs, d_vs, d_von, d_pt, d_ls, d_fs};
            exp = model(C_DEF, n_def);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL def_scan n=%0d got x=%0d y=%0d f=%b required x=%0d y=%0d f=%b",
                         n_def, got[25:16], got[15:6], got[5:0], exp[25:16], exp[15:6], exp[5:0]);
            end
            got = {f_x, f_y, f_hs, f_vs, f_von, f_pt, f_ls, f_fs};
            exp = model(C_FAST, n_fast);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL fast_scan n=%0d got x=%0d y=%0d f=%b required x=%0d y=%0d f=%b",
                         n_fast, got[25:16], got[15:6], got[5:0], exp[25:16], exp[15:6], exp[5:0]);
            end
            if (d_ls === 1'b1) ls_def++;
        end
        checks++;
        if (ls_def !== ((n_def - 1) / 4) / 800) begin
            errors++;
            $display("FAIL def_line_count got=%0d required=%0d", ls_def, ((n_def - 1) / 4) / 800);
        end
    endtask

    task automatic test_small_frames();
        logic [25:0] got, exp;
        int fs_cnt = 0, cycles;
        @(negedge clk);
        rst_small = 1'b0;
        @(negedge clk);
        rst_small = 1'b1;
        cycles = 2 * SMALL_FRAME_CLKS + int'($urandom_range(20, 400));
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            got = {s_x, s_y, s_hs, s_vs, s_von, s_pt, s_ls, s_fs};
            exp = model(C_SMALL, n_small);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL small_scan n=%0d got x=%0d y=%0d f=%b required x=%0d y=%0d f=%b",
                         n_small, got[25:16], got[15:6], got[5:0], exp[25:16], exp[15:6], exp[5:0]);
            end
`ifdef VGA_FRAME_CNT_EN
            checks++;
            if (s_fc !== 16'(model_frames(C_SMALL, n_small))) begin
                errors++;
                $display("FAIL small_frame_cnt n=%0d got=%0d required=%0d",
                         n_small, s_fc, model_frames(C_SMALL, n_small));
            end
`endif
            if (s_fs === 1'b1) fs_cnt++;
        end
        checks++;
        if (fs_cnt !== model_frames(C_SMALL, n_small)) begin
            errors++;
            $display("FAIL small_frame_count got=%0d required=%0d", fs_cnt, model_frames(C_SMALL, n_small));
        end
    endtask

    task automatic test_mid_reset();
        logic [25:0] got, exp;
        int run;
        for (int k = 0; k < 3; k++) begin
            run = int'($urandom_range(50, 1500));
            repeat (run) @(negedge clk);
            rst_small = 1'b0;
            @(negedge clk);
            rst_small = 1'b1;
            got = {s_x, s_y, s_hs, s_vs, s_von, s_pt, s_ls, s_fs};
            checks++;
            if (got !== {10'd0, 10'd0, 1'b1, 1'b1, 4'b0000}) begin
                errors++;
                $display("FAIL mid_reset_values got=%h required=%h", got, {10'd0, 10'd0, 1'b1, 1'b1, 4'b0000});
            end
            for (int i = 0; i < 600; i++) begin
                @(negedge clk);
                got = {s_x, s_y, s_hs, s_vs, s_von, s_pt, s_ls, s_fs};
                exp = model(C_SMALL, n_small);
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL restart_scan n=%0d got x=%0d y=%0d f=%b required x=%0d y=%0d f=%b",
                             n_small, got[25:16], got[15:6], got[5:0], exp[25:16], exp[15:6], exp[5:0]);
                end
            end
        end
    endtask

`ifdef VGA_FRAME_CNT_EN
    task automatic test_frame_cnt_wrap();
        int guard = 0;
        @(negedge clk);
        rst_small = 1'b0;
        @(negedge clk);
        rst_small = 1'b1;
        while (n_small < SMALL_FRAME_CLKS - 10 && guard < 3 * SMALL_FRAME_CLKS) begin
            @(negedge clk);
            guard++;
        end
        force u_small.r_frame_cnt = 16'hFFFF;
        @(negedge clk);
        release u_small.r_frame_cnt;
        while (s_fs !== 1'b1 && guard < 3 * SMALL_FRAME_CLKS) begin
            checks++;
            if (s_fc !== 16'hFFFF) begin
                errors++;
                $display("FAIL frame_cnt_hold got=%h required=ffff", s_fc);
            end
            @(negedge clk);
            guard++;
        end
        checks++;
        if (s_fs !== 1'b1 || n_small !== SMALL_FRAME_CLKS + 1) begin
            errors++;
            $display("FAIL frame_start_timing got n=%0d fs=%b required n=%0d fs=1", n_small, s_fs, SMALL_FRAME_CLKS + 1);
        end
        checks++;
        if (s_fc !== 16'h0000) begin
            errors++;
            $display("FAIL frame_cnt_wrap got=%h required=0000", s_fc);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_scan_lines();
        test_small_frames();
        test_mid_reset();
`ifdef VGA_FRAME_CNT_EN
        test_frame_cnt_wrap();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
